// File: rtl/cs3710_isa_pkg.sv
// Shared ISA definitions for the CS3710 16-bit multicycle core.
//   - FSM state codes (plain localparams so older code can share them)
//   - opcode / func field constants
//   - writeback mux (regSrc) encodings
//   - instruction class enum produced by inst_decoder
//   - helper that tells which immediate opcodes sign-extend imm8
package cs3710_isa_pkg;

  // Sequencer states
  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;

  // oper field (IR[15:12])
  localparam logic [3:0] OP_REG     = 4'b0000;
  localparam logic [3:0] OP_ADDI    = 4'b0101;
  localparam logic [3:0] OP_ADDCI   = 4'b0111;
  localparam logic [3:0] OP_SPECIAL = 4'b0100;
  localparam logic [3:0] OP_SHIFT   = 4'b1000;
  localparam logic [3:0] OP_SUBI    = 4'b1001;
  localparam logic [3:0] OP_SUBCI   = 4'b1010;
  localparam logic [3:0] OP_CMPI    = 4'b1011;
  localparam logic [3:0] OP_BCOND   = 4'b1100;
  localparam logic [3:0] OP_MOVI    = 4'b1101;
  localparam logic [3:0] OP_MULI    = 4'b1110;

  // func field (IR[7:4])
  localparam logic [3:0] FN_CMP   = 4'b1011;
  localparam logic [3:0] FN_TEST  = 4'b1111;
  localparam logic [3:0] FN_LOAD  = 4'b0000;
  localparam logic [3:0] FN_STOR  = 4'b0100;
  localparam logic [3:0] FN_JAL   = 4'b1000;
  localparam logic [3:0] FN_JCOND = 4'b1100;
  localparam logic [3:0] FN_SCOND = 4'b1101;
  localparam logic [3:0] FN_LSHR  = 4'b0100;  // register shift amount
  localparam logic [3:0] FN_ASHR  = 4'b0110;  // register shift amount

  // Writeback mux select
  localparam logic [1:0] REGSRC_ALU = 2'b00;
  localparam logic [1:0] REGSRC_MEM = 2'b01;
  localparam logic [1:0] REGSRC_PC  = 2'b10;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_CMP, CLS_LOAD, CLS_STORE,
    CLS_JAL, CLS_JUMP, CLS_BRANCH, CLS_ILLEGAL
  } instClass_t;

  // Arithmetic immediates and branch displacements are signed; logical
  // immediates and LUI are not.
  function automatic logic isSextImm(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_ADDCI) || (op == OP_SUBI) ||
           (op == OP_SUBCI) || (op == OP_CMPI) || (op == OP_MOVI) ||
           (op == OP_MULI) || (op == OP_BCOND);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Memory port between the sequencer (master) and instruction/data memory
// (slave).
//   memRd/memWr : access requests, held until memReady or timeout
//   addrSel     : 0 = PC drives the address, 1 = Rsrc drives it
//   memData     : read data, valid with memReady
//   memReady    : one-cycle acknowledge
interface multicycle_control_fsm_if #(
  parameter int INST_W = 16
) ();
  logic [INST_W-1:0] memData;
  logic              memReady;
  logic              memRd;
  logic              memWr;
  logic              addrSel;

  modport master (
    input  memData, memReady,
    output memRd, memWr, addrSel
  );

  modport slave (
    input  memRd, memWr, addrSel,
    output memData, memReady
  );
endinterface

// File: rtl/inst_decoder.sv
// Combinational instruction classifier.
//   oper, func : IR[15:12], IR[7:4]
//   cls        : instruction class steering the sequencer
//   srcSel     : ALU B operand, 0 = register, 1 = immediate
//   immSext    : 1 = sign-extend imm8, 0 = zero-extend
module inst_decoder
  import cs3710_isa_pkg::*;
(
  input  logic [3:0]  oper,
  input  logic [3:0]  func,
  output instClass_t  cls,
  output logic        srcSel,
  output logic        immSext
);

  always_comb begin
    cls     = CLS_ALU;
    srcSel  = 1'b1;
    immSext = isSextImm(oper);
    case (oper)
      OP_REG: begin
        srcSel = 1'b0;
        if (func == FN_CMP || func == FN_TEST) cls = CLS_CMP;
      end
      OP_SPECIAL: begin
        case (func)
          FN_LOAD:  cls = CLS_LOAD;
          FN_STOR:  cls = CLS_STORE;
          FN_JAL:   cls = CLS_JAL;
          FN_JCOND: cls = CLS_JUMP;
          FN_SCOND: cls = CLS_ALU;   // writes a flag value back like an ALU op
          default:  cls = CLS_ILLEGAL;
        endcase
      end
      OP_SHIFT: begin
        // func 0000-0011 take the amount from imm; 0100/0110 from Rsrc
        if (func <= 4'b0011)                        srcSel = 1'b1;
        else if (func == FN_LSHR || func == FN_ASHR) srcSel = 1'b0;
        else                                         cls    = CLS_ILLEGAL;
      end
      OP_BCOND: cls = CLS_BRANCH;
      OP_CMPI:  cls = CLS_CMP;
      default:  cls = CLS_ALU;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle sequencer for the CS3710 core.
// Fetches an instruction over the memory port into IR, decodes it and walks
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB], driving the datapath strobes.
//   clk, reset          : clock, synchronous active-high reset
//   bus (master)        : memory request/ack port
//   oper/func/rDest/rSrc: IR fields for the ALU controller and regfile
//   srcSel, immSext     : ALU operand controls
//   regWrEn, regSrc     : register writeback strobe and mux select
//   pcWrEn, pcSrc       : PC write strobe, 0 = PC+1, 1 = ALU result
//   busErr, illegal     : one-cycle error pulses
// All strobes are Moore outputs of state + IR. busErr is registered, so it
// appears in the first cycle of the restarted FETCH after an abort.
module multicycle_control_fsm
  import cs3710_isa_pkg::*;
#(
  parameter int INST_W  = 16,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_control_fsm_if.master bus,
  output logic [3:0]               oper,
  output logic [3:0]               func,
  output logic [3:0]               rDest,
  output logic [3:0]               rSrc,
  output logic                     srcSel,
  output logic                     immSext,
  output logic                     regWrEn,
  output logic [1:0]               regSrc,
  output logic                     pcWrEn,
  output logic                     pcSrc,
  output logic                     busErr,
  output logic                     illegal
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [2:0]        state;
  logic [INST_W-1:0] ir;
  logic [CNT_W-1:0]  waitCnt;
  instClass_t        cls;

  assign oper  = ir[15:12];
  assign rDest = ir[11:8];
  assign func  = ir[7:4];
  assign rSrc  = ir[3:0];

  inst_decoder uDec (
    .oper    (oper),
    .func    (func),
    .cls     (cls),
    .srcSel  (srcSel),
    .immSext (immSext)
  );

  // A memReady on the same cycle the counter hits the limit wins over abort.
  logic atLimit;
  assign atLimit = (waitCnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      ir      <= '0;
      waitCnt <= '0;
      busErr  <= 1'b0;
    end else begin
      busErr <= 1'b0;
      case (state)
        FETCH: begin
          if (bus.memReady) begin
            ir      <= bus.memData;
            waitCnt <= '0;
            state   <= DECODE;
          end else if (atLimit) begin
            busErr  <= 1'b1;
            waitCnt <= '0;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        DECODE: state <= (cls == CLS_ILLEGAL) ? FETCH : EXEC;
        EXEC: begin
          case (cls)
            CLS_JAL, CLS_JUMP, CLS_BRANCH: state <= FETCH;
            CLS_LOAD, CLS_STORE:           state <= MEM;
            default:                       state <= WB;
          endcase
        end
        MEM: begin
          if (bus.memReady) begin
            waitCnt <= '0;
            state   <= (cls == CLS_LOAD) ? WB : FETCH;
          end else if (atLimit) begin
            // aborted LOAD never reaches WB, so no register write happens
            busErr  <= 1'b1;
            waitCnt <= '0;
            state   <= FETCH;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        WB:      state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  logic isXfer;
  assign isXfer = (cls == CLS_JAL) || (cls == CLS_JUMP) || (cls == CLS_BRANCH);

  always_comb begin
    bus.memRd   = (state == FETCH) || (state == MEM && cls == CLS_LOAD);
    bus.memWr   = (state == MEM) && (cls == CLS_STORE);
    bus.addrSel = (state == MEM);
    pcWrEn      = (state == DECODE) || (state == EXEC && isXfer);
    pcSrc       = (state == EXEC) && isXfer;
    illegal     = (state == DECODE) && (cls == CLS_ILLEGAL);
    regWrEn     = 1'b0;
    regSrc      = REGSRC_ALU;
    if (state == EXEC && cls == CLS_JAL) begin
      regWrEn = 1'b1;
      regSrc  = REGSRC_PC;
    end else if (state == WB) begin
      regWrEn = (cls != CLS_CMP);
      regSrc  = (cls == CLS_LOAD) ? REGSRC_MEM : REGSRC_ALU;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm (TIMEOUT overridden to 4).
// Each table row is one instruction plus memory ack delays and the expected
// per-instruction strobe totals; a small responder acks accesses after the
// requested number of wait cycles.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] oper, func, rDest, rSrc;
  logic       srcSel, immSext, regWrEn, pcWrEn, pcSrc, busErr, illegal;
  logic [1:0] regSrc;

  int total = 0;
  int bad   = 0;

  multicycle_control_fsm_if #(.INST_W(16)) mif ();

  multicycle_control_fsm #(.INST_W(16), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(mif.master),
    .oper(oper), .func(func), .rDest(rDest), .rSrc(rSrc),
    .srcSel(srcSel), .immSext(immSext), .regWrEn(regWrEn), .regSrc(regSrc),
    .pcWrEn(pcWrEn), .pcSrc(pcSrc), .busErr(busErr), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] inst;
    int          fD, mD;     // wait cycles before ack in FETCH / MEM
    bit          junk;       // drive memReady=1 when no access is pending
    int          cyc;        // cycles until the next FETCH begins
    int          nReg;
    logic [1:0]  rsrc;
    int          nPc, nPcAlu, nRd, nWr, nIll, nBus;
    bit          ss, sx;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic runInst(input vec_t v, input string nm);
    int cyc = 0, waitCnt = 0;
    int nReg = 0, nPc = 0, nPcAlu = 0, nRd = 0, nWr = 0, nIll = 0, nBus = 0;
    logic [1:0] rsrc = 2'b00;
    bit fetchDone = 0, done = 0, cap = 0;
    logic [3:0] cOp = 0, cFn = 0, cRd = 0, cRs = 0;
    logic cSs = 0, cSx = 0;
    while (!done && cyc < 40) begin
      if (fetchDone && mif.memRd && !mif.addrSel) begin
        done = 1;
        if (busErr) nBus++;
      end else begin
        if (cyc > 0 && busErr) nBus++;
        if (fetchDone && !cap) begin
          cap = 1; cOp = oper; cFn = func; cRd = rDest; cRs = rSrc;
          cSs = srcSel; cSx = immSext;
        end
        if (regWrEn) begin nReg++; rsrc = regSrc; end
        if (pcWrEn) begin nPc++; if (pcSrc) nPcAlu++; end
        if (mif.memRd && mif.addrSel) nRd++;
        if (mif.memWr) nWr++;
        if (illegal) nIll++;
        if (mif.memRd || mif.memWr) begin
          if (waitCnt == (mif.addrSel ? v.mD : v.fD)) begin
            mif.memReady = 1'b1;
            mif.memData  = mif.addrSel ? 16'h5A5A : v.inst;
            waitCnt = 0;
            if (!mif.addrSel) fetchDone = 1;
          end else begin
            mif.memReady = 1'b0;
            waitCnt++;
          end
        end else begin
          mif.memReady = v.junk;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    mif.memReady = 1'b0;
    chk({nm, " completed"}, int'(done), 1);
    chk({nm, " cycles"}, cyc, v.cyc);
    chk({nm, " regWr count"}, nReg, v.nReg);
    if (v.nReg > 0) chk({nm, " regSrc"}, int'(rsrc), int'(v.rsrc));
    chk({nm, " pcWr count"}, nPc, v.nPc);
    chk({nm, " pcSrc=1 count"}, nPcAlu, v.nPcAlu);
    chk({nm, " mem rd cycles"}, nRd, v.nRd);
    chk({nm, " mem wr cycles"}, nWr, v.nWr);
    chk({nm, " illegal"}, nIll, v.nIll);
    chk({nm, " busErr"}, nBus, v.nBus);
    chk({nm, " oper"}, int'(cOp), int'(v.inst[15:12]));
    chk({nm, " func"}, int'(cFn), int'(v.inst[7:4]));
    chk({nm, " rDest"}, int'(cRd), int'(v.inst[11:8]));
    chk({nm, " rSrc"}, int'(cRs), int'(v.inst[3:0]));
    if (v.nIll == 0) begin
      chk({nm, " srcSel"}, int'(cSs), int'(v.ss));
      chk({nm, " immSext"}, int'(cSx), int'(v.sx));
    end
  endtask

  initial begin
    //               inst     fD mD jk cyc reg rsrc  pc alu rd wr il be ss sx
    tbl.push_back('{16'h0152, 0, 0, 0, 4, 1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0}); // ADD
    tbl.push_back('{16'h0152, 4, 0, 1, 8, 1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0}); // ack at limit
    tbl.push_back('{16'h0152, 5, 0, 0, 9, 1, 2'b00, 1, 0, 0, 0, 0, 1, 0, 0}); // fetch timeout
    tbl.push_back('{16'h4304, 0, 2, 0, 7, 1, 2'b01, 1, 0, 3, 0, 0, 0, 1, 0}); // LOAD
    tbl.push_back('{16'h4304, 0, 5, 0, 8, 0, 2'b00, 1, 0, 5, 0, 0, 1, 1, 0}); // LOAD timeout
    tbl.push_back('{16'h4244, 1, 0, 0, 5, 0, 2'b00, 1, 0, 0, 1, 0, 0, 1, 0}); // STOR
    tbl.push_back('{16'h4244, 0, 5, 0, 8, 0, 2'b00, 1, 0, 0, 5, 0, 1, 1, 0}); // STOR timeout
    tbl.push_back('{16'hB5FF, 0, 0, 0, 4, 0, 2'b00, 1, 0, 0, 0, 0, 0, 1, 1}); // CMPI
    tbl.push_back('{16'h4E82, 0, 0, 0, 3, 1, 2'b10, 2, 1, 0, 0, 0, 0, 1, 0}); // JAL
    tbl.push_back('{16'h4EC3, 0, 0, 0, 3, 0, 2'b00, 2, 1, 0, 0, 0, 0, 1, 0}); // Jcond
    tbl.push_back('{16'hC1F0, 0, 0, 0, 3, 0, 2'b00, 2, 1, 0, 0, 0, 0, 1, 1}); // Bcond
    tbl.push_back('{16'h1233, 0, 0, 0, 4, 1, 2'b00, 1, 0, 0, 0, 0, 0, 1, 0}); // ANDI
    tbl.push_back('{16'hD780, 0, 0, 0, 4, 1, 2'b00, 1, 0, 0, 0, 0, 0, 1, 1}); // MOVI
    tbl.push_back('{16'hF712, 0, 0, 0, 4, 1, 2'b00, 1, 0, 0, 0, 0, 0, 1, 0}); // LUI
    tbl.push_back('{16'h8301, 0, 0, 0, 4, 1, 2'b00, 1, 0, 0, 0, 0, 0, 1, 0}); // shift imm
    tbl.push_back('{16'h8362, 0, 0, 0, 4, 1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0}); // shift reg
    tbl.push_back('{16'h01F2, 0, 0, 0, 4, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0}); // TEST
    tbl.push_back('{16'h02B3, 0, 0, 0, 4, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0}); // CMP
    tbl.push_back('{16'h4F2A, 0, 0, 0, 2, 0, 2'b00, 1, 0, 0, 0, 1, 0, 0, 0}); // bad special
    tbl.push_back('{16'h8352, 0, 0, 0, 2, 0, 2'b00, 1, 0, 0, 0, 1, 0, 0, 0}); // bad shift

    reset = 1'b1;
    mif.memReady = 1'b0;
    mif.memData  = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset memRd",   int'(mif.memRd), 1);
    chk("reset memWr",   int'(mif.memWr), 0);
    chk("reset addrSel", int'(mif.addrSel), 0);
    chk("reset regWrEn", int'(regWrEn), 0);
    chk("reset pcWrEn",  int'(pcWrEn), 0);
    chk("reset pcSrc",   int'(pcSrc), 0);
    chk("reset busErr",  int'(busErr), 0);
    chk("reset illegal", int'(illegal), 0);
    chk("reset IR",      int'({oper, rDest, func, rSrc}), 0);
    chk("reset srcSel",  int'(srcSel), 0);
    reset = 1'b0;

    foreach (tbl[i]) runInst(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a STOR access abandons it.
    mif.memReady = 1'b1; mif.memData = 16'h4244;
    @(posedge clk); #1;              // DECODE
    mif.memReady = 1'b0;
    @(posedge clk); #1;              // EXEC
    @(posedge clk); #1;              // MEM
    chk("midstor memWr before reset", int'(mif.memWr), 1);
    chk("midstor addrSel before reset", int'(mif.addrSel), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midstor memWr after reset", int'(mif.memWr), 0);
    chk("midstor memRd after reset", int'(mif.memRd), 1);
    chk("midstor addrSel after reset", int'(mif.addrSel), 0);
    chk("midstor IR cleared", int'({oper, rDest, func, rSrc}), 0);
    reset = 1'b0;
    // wait counter must restart from zero: an ack at the limit still succeeds
    runInst('{16'h0152, 4, 0, 0, 8, 1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0}, "post-reset ADD");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
